// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg
//   Shared types for the retire-stage trace path: the record kind encoding,
//   the default-width trace record layout and the retire classifier.
//   No ports (package).
package cpu_trace_pkg;

  localparam int TRC_ADDR_W = 16;
  localparam int TRC_DATA_W = 16;
  localparam int TRC_REG_W  = 4;
  localparam int TRC_KIND_W = 3;

  typedef enum logic [TRC_KIND_W-1:0] {
    KIND_ALU   = 3'd0,
    KIND_LOAD  = 3'd1,
    KIND_STORE = 3'd2,
    KIND_OTHER = 3'd3,
    KIND_HALT  = 3'd4
  } trace_kind_e;

  // Record layout at the default widths; the top builds the same layout
  // from its own parameters so non-default widths stay consistent.
  typedef struct packed {
    trace_kind_e            kind;
    logic [TRC_ADDR_W-1:0]  pc;
    logic [TRC_REG_W-1:0]   regIdx;
    logic [TRC_DATA_W-1:0]  value;
    logic [TRC_ADDR_W-1:0]  addr;
  } trace_rec_t;

  // Priority matters: a load also asserts regwrite, and a halt may carry
  // stray memwrite, so the order below is the architectural meaning.
  function automatic trace_kind_e classifyRetire(input logic regWrite,
                                                 input logic memRead,
                                                 input logic memWrite,
                                                 input logic halt);
    if (regWrite && memRead) return KIND_LOAD;
    if (regWrite)            return KIND_ALU;
    if (halt)                return KIND_HALT;
    if (memWrite)            return KIND_STORE;
    return KIND_OTHER;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
//   Generic DEPTH x WIDTH synchronous FIFO. A push while full is accepted
//   only when a pop happens in the same cycle (level then stays unchanged);
//   a pop while empty is ignored. The head output reads 0 while empty so
//   downstream fields are clean without resetting the storage array.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (control only)
//   push, pushData    write request and data
//   pop               read request (consumes the head when not empty)
//   headData          current head entry (0 when empty)
//   notEmpty, full    status flags from registered occupancy
//   level             occupancy, 0..DEPTH
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic                     notEmpty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign notEmpty = (level != '0);
  assign full     = (level == LVL_W'(DEPTH));
  assign doPop    = pop & notEmpty;
  assign doPush   = push & (~full | doPop);
  assign headData = notEmpty ? mem[rdPtr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is data only; occupancy gating makes its reset value irrelevant.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/commit_trace_unit.sv
// commit_trace_unit
//   Retire-stage monitor. Classifies each write-back commit, keeps
//   instruction/cycle/bubble/drop counters, latches halt and timeout, and
//   queues one trace record per accepted retire for a valid/ready consumer.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wb_valid, wb_pc, wb_regwrite,
//   wb_memread, wb_memwrite, wb_halt,
//   wb_reg, wb_regdata, wb_addr,
//   wb_memdata                       retiring instruction (wb_valid=0: bubble)
//   trc_valid, trc_ready             head-of-queue handshake
//   trc_kind, trc_pc, trc_reg,
//   trc_value, trc_addr              head record fields (0 when empty)
//   trc_level                        queue occupancy
//   inst_count, cycle_count,
//   bubble_count, drop_count         saturating counters
//   halted, timeout                  sticky status flags
module commit_trace_unit
  import cpu_trace_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_pc,
  input  logic                     wb_regwrite,
  input  logic                     wb_memread,
  input  logic                     wb_memwrite,
  input  logic                     wb_halt,
  input  logic [REG_W-1:0]         wb_reg,
  input  logic [DATA_W-1:0]        wb_regdata,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_memdata,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [2:0]               trc_kind,
  output logic [ADDR_W-1:0]        trc_pc,
  output logic [ADDR_W-1:0]        trc_addr,
  output logic [REG_W-1:0]         trc_reg,
  output logic [DATA_W-1:0]        trc_value,
  output logic [$clog2(DEPTH):0]   trc_level,
  output logic [CNT_W-1:0]         inst_count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         bubble_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     halted,
  output logic                     timeout
);

  typedef struct packed {
    trace_kind_e          kind;
    logic [ADDR_W-1:0]    pc;
    logic [REG_W-1:0]     regIdx;
    logic [DATA_W-1:0]    value;
    logic [ADDR_W-1:0]    addr;
  } recT;

  localparam int REC_W = $bits(recT);
  // Compare against the pre-increment count so the flag rises on the same
  // edge that brings cycle_count to TIMEOUT.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  trace_kind_e      retireKind;
  recT              pushRec;
  recT              headRec;
  logic [REC_W-1:0] headBits;
  logic             accept;
  logic             fifoFull;
  logic             dropRec;

  assign accept     = wb_valid & ~halted;
  assign retireKind = classifyRetire(wb_regwrite, wb_memread, wb_memwrite, wb_halt);

  // Fields a kind does not use are zeroed so records compare cleanly.
  always_comb begin
    pushRec      = '0;
    pushRec.kind = retireKind;
    pushRec.pc   = wb_pc;
    case (retireKind)
      KIND_ALU: begin
        pushRec.regIdx = wb_reg;
        pushRec.value  = wb_regdata;
      end
      KIND_LOAD: begin
        pushRec.regIdx = wb_reg;
        pushRec.value  = wb_regdata;
        pushRec.addr   = wb_addr;
      end
      KIND_STORE: begin
        pushRec.value  = wb_memdata;
        pushRec.addr   = wb_addr;
      end
      default: ;
    endcase
  end

  // When full, the head exists, so a ready consumer frees the slot this cycle.
  assign dropRec = accept & fifoFull & ~trc_ready;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .pushData (pushRec),
    .pop      (trc_ready),
    .headData (headBits),
    .notEmpty (trc_valid),
    .full     (fifoFull),
    .level    (trc_level)
  );

  assign headRec   = recT'(headBits);
  assign trc_kind  = headRec.kind;
  assign trc_pc    = headRec.pc;
  assign trc_reg   = headRec.regIdx;
  assign trc_value = headRec.value;
  assign trc_addr  = headRec.addr;

  // Everything freezes once halted; only reset releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_count   <= '0;
      cycle_count  <= '0;
      bubble_count <= '0;
      drop_count   <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
    end else if (!halted) begin
      cycle_count <= satInc(cycle_count);
      if (!wb_valid) bubble_count <= satInc(bubble_count);
      if (wb_valid)  inst_count   <= satInc(inst_count);
      if (dropRec)   drop_count   <= satInc(drop_count);
      if (cycle_count == TIMEOUT_LAST) timeout <= 1'b1;
      if (wb_valid && retireKind == KIND_HALT) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_trace_unit.sv
module tb_commit_trace_unit;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 8;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_pc = '0;
  logic              wb_regwrite = 1'b0;
  logic              wb_memread = 1'b0;
  logic              wb_memwrite = 1'b0;
  logic              wb_halt = 1'b0;
  logic [REG_W-1:0]  wb_reg = '0;
  logic [DATA_W-1:0] wb_regdata = '0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_memdata = '0;
  logic              trc_valid;
  logic              trc_ready = 1'b0;
  logic [2:0]        trc_kind;
  logic [ADDR_W-1:0] trc_pc;
  logic [ADDR_W-1:0] trc_addr;
  logic [REG_W-1:0]  trc_reg;
  logic [DATA_W-1:0] trc_value;
  logic [LVL_W-1:0]  trc_level;
  logic [CNT_W-1:0]  inst_count;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  bubble_count;
  logic [CNT_W-1:0]  drop_count;
  logic              halted;
  logic              timeout;

  commit_trace_unit #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .REG_W (REG_W),
    .DEPTH (DEPTH), .CNT_W (CNT_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .wb_valid (wb_valid), .wb_pc (wb_pc),
    .wb_regwrite (wb_regwrite), .wb_memread (wb_memread),
    .wb_memwrite (wb_memwrite), .wb_halt (wb_halt),
    .wb_reg (wb_reg), .wb_regdata (wb_regdata),
    .wb_addr (wb_addr), .wb_memdata (wb_memdata),
    .trc_valid (trc_valid), .trc_ready (trc_ready),
    .trc_kind (trc_kind), .trc_pc (trc_pc), .trc_addr (trc_addr),
    .trc_reg (trc_reg), .trc_value (trc_value), .trc_level (trc_level),
    .inst_count (inst_count), .cycle_count (cycle_count),
    .bubble_count (bubble_count), .drop_count (drop_count),
    .halted (halted), .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of records plus plain integer counters.
  typedef struct {
    int kind;
    int pc;
    int rg;
    int val;
    int addr;
  } rec_t;

  rec_t q[$];
  int   mInst, mCyc, mBub, mDrop;
  bit   mHalted, mTimeout;
  int   nAssert = 0;
  int   nFail = 0;
  bit   chkEn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c);
    return (c < CMAX) ? c + 1 : c;
  endfunction

  task automatic modelClear();
    q.delete();
    mInst = 0; mCyc = 0; mBub = 0; mDrop = 0;
    mHalted = 1'b0; mTimeout = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic modelClock();
    bit   pop;
    bit   pushIt;
    rec_t r;
    if (!rst_n) begin
      modelClear();
      return;
    end
    pop    = (q.size() > 0) && trc_ready;
    pushIt = 1'b0;
    r      = '{default: 0};
    if (!mHalted) begin
      if (mCyc == TIMEOUT - 1) mTimeout = 1'b1;
      mCyc = sat(mCyc);
      if (!wb_valid) begin
        mBub = sat(mBub);
      end else begin
        r.pc = int'(wb_pc);
        if (wb_regwrite && wb_memread) begin
          r.kind = 1; r.rg = int'(wb_reg); r.val = int'(wb_regdata); r.addr = int'(wb_addr);
        end else if (wb_regwrite) begin
          r.kind = 0; r.rg = int'(wb_reg); r.val = int'(wb_regdata);
        end else if (wb_halt) begin
          r.kind = 4;
        end else if (wb_memwrite) begin
          r.kind = 2; r.val = int'(wb_memdata); r.addr = int'(wb_addr);
        end else begin
          r.kind = 3;
        end
        mInst = sat(mInst);
        if (r.kind == 4) mHalted = 1'b1;
        if (q.size() < DEPTH || pop) pushIt = 1'b1;
        else mDrop = sat(mDrop);
      end
    end
    if (pop) void'(q.pop_front());
    if (pushIt) q.push_back(r);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      rec_t h;
      h = '{default: 0};
      if (q.size() > 0) h = q[0];
      check("trc_valid", trc_valid, (q.size() > 0) ? 1 : 0);
      check("trc_kind", trc_kind, h.kind);
      check("trc_pc", trc_pc, h.pc);
      check("trc_reg", trc_reg, h.rg);
      check("trc_value", trc_value, h.val);
      check("trc_addr", trc_addr, h.addr);
      check("trc_level", trc_level, q.size());
      check("inst_count", inst_count, mInst);
      check("cycle_count", cycle_count, mCyc);
      check("bubble_count", bubble_count, mBub);
      check("drop_count", drop_count, mDrop);
      check("halted", halted, mHalted);
      check("timeout", timeout, mTimeout);
    end
  end

  task automatic tick();
    @(posedge clk);
    modelClock();
    #1;
  endtask

  task automatic setIn(input logic v, input int pc, input logic rw, input logic mr,
                       input logic mw, input logic h, input int rg, input int rd,
                       input int a, input int md);
    wb_valid = v; wb_pc = ADDR_W'(pc);
    wb_regwrite = rw; wb_memread = mr; wb_memwrite = mw; wb_halt = h;
    wb_reg = REG_W'(rg); wb_regdata = DATA_W'(rd);
    wb_addr = ADDR_W'(a); wb_memdata = DATA_W'(md);
  endtask

  task automatic idle();
    setIn(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle();
    modelClear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int expPc[4];

  initial begin
    chkEn = 1'b1;
    modelClear();

    // Reset state and a single ALU retire.
    doReset();
    check("rst trc_valid", trc_valid, 0);
    check("rst trc_level", trc_level, 0);
    check("rst inst_count", inst_count, 0);
    check("rst halted", halted, 0);
    check("rst timeout", timeout, 0);
    trc_ready = 1'b1;
    setIn(1'b1, 'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 3, 'h00A5, 'h7777, 'h5555);
    tick();
    check("alu valid", trc_valid, 1);
    check("alu kind", trc_kind, 0);
    check("alu pc", trc_pc, 'h0004);
    check("alu reg", trc_reg, 3);
    check("alu value", trc_value, 'h00A5);
    check("alu addr", trc_addr, 0);
    check("alu inst_count", inst_count, 1);

    // Load then store.
    doReset();
    trc_ready = 1'b1;
    setIn(1'b1, 'h0006, 1'b1, 1'b1, 1'b0, 1'b0, 1, 'h1234, 'h0010, 'h9999);
    tick();
    check("load kind", trc_kind, 1);
    check("load addr", trc_addr, 'h0010);
    check("load value", trc_value, 'h1234);
    check("load reg", trc_reg, 1);
    setIn(1'b1, 'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 'hF, 'hAAAA, 'h0020, 'hBEEF);
    tick();
    check("store kind", trc_kind, 2);
    check("store value", trc_value, 'hBEEF);
    check("store reg", trc_reg, 0);
    check("store addr", trc_addr, 'h0020);
    check("store inst_count", inst_count, 2);

    // Overflow with consumer stalled, then push+pop while full.
    doReset();
    trc_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      setIn(1'b1, 'h100 + i, 1'b1, 1'b0, 1'b0, 1'b0, i, 'h50 + i, 0, 0);
      tick();
    end
    check("full level", trc_level, 4);
    check("full drop_count", drop_count, 2);
    check("full head pc", trc_pc, 'h100);
    trc_ready = 1'b1;
    setIn(1'b1, 'h106, 1'b1, 1'b0, 1'b0, 1'b0, 6, 'h56, 0, 0);
    tick();
    check("pushpop level", trc_level, 4);
    check("pushpop drop_count", drop_count, 2);
    idle();
    expPc = '{'h101, 'h102, 'h103, 'h106};
    for (int i = 0; i < 4; i++) begin
      check("drain pc", trc_pc, expPc[i]);
      tick();
    end
    check("drained level", trc_level, 0);
    check("drained valid", trc_valid, 0);

    // Bubbles, then halt, then ignored retires.
    doReset();
    trc_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      setIn((i % 2) == 0, 'h200 + i, 1'b1, 1'b0, 1'b0, 1'b0, 2, i, 0, 0);
      tick();
    end
    setIn(1'b1, 'h20A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      setIn(1'b1, 'h210 + i, 1'b1, 1'b0, 1'b0, 1'b0, 4, i, 0, 0);
      tick();
    end
    check("halt bubble_count", bubble_count, 5);
    check("halt inst_count", inst_count, 6);
    check("halt halted", halted, 1);
    check("halt cycle_count", cycle_count, 11);

    // Timeout, then asynchronous reset mid-run.
    doReset();
    trc_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      setIn(i < 3, 'h300 + i, 1'b1, 1'b0, 1'b0, 1'b0, 5, i, 0, 0);
      tick();
    end
    check("pre timeout", timeout, 0);
    idle();
    tick();
    check("timeout set", timeout, 1);
    check("timeout cycle_count", cycle_count, 8);
    repeat (2) tick();
    check("timeout sticky", timeout, 1);
    check("pre-reset level", trc_level, 3);
    rst_n = 1'b0;
    modelClear();
    #1;
    check("async trc_valid", trc_valid, 0);
    check("async level", trc_level, 0);
    check("async inst_count", inst_count, 0);
    check("async cycle_count", cycle_count, 0);
    check("async timeout", timeout, 0);
    check("async trc_pc", trc_pc, 0);

    // Randomized segments, each from reset.
    for (int seg = 0; seg < 6; seg++) begin
      doReset();
      for (int c = 0; c < 60; c++) begin
        setIn($urandom_range(0, 3) != 0, int'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(0, 24) == 0, int'($urandom), int'($urandom),
              int'($urandom), int'($urandom));
        trc_ready = ($urandom_range(0, 2) != 0) ^ (seg == 2);
        tick();
      end
    end

    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
